sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4, meaning maximum in-flight accepted requests (power of two, 2..8).
REQ-002 SHALL have parameter STARVE_LIM, default 4, meaning consecutive data grants allowed while an inst request waits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports inst_sram_req/wr  input  1 each; inst_sram_wen  input  4; inst_sram_addr/wdata  input  32 each: instruction master request.
REQ-006 SHALL have ports inst_sram_addr_ok/data_ok  output  1 each; inst_sram_rdata  output  32: instruction master response.
REQ-007 SHALL have ports data_sram_req/wr  input  1 each; data_sram_wen  input  4; data_sram_addr/wdata  input  32 each: data master request.
REQ-008 SHALL have ports data_sram_addr_ok/data_ok  output  1 each; data_sram_rdata  output  32: data master response.
REQ-009 SHALL have ports sram_req/wr  output  1 each; sram_wen  output  4; sram_addr/wdata  output  32 each: shared slave request.
REQ-010 SHALL have ports sram_addr_ok/data_ok  input  1 each; sram_rdata  input  32: shared slave response.
REQ-011 SHALL have port err_unexp_resp  output  1  sticky flag, slave data_ok seen with no request outstanding.

Function
REQ-012 SHALL route the selected master's wr/wen/addr/wdata combinationally to the slave; sram_req = selected master req AND NOT full.
REQ-013 SHALL select data over inst when both request, no lock is held, and the starvation counter is below STARVE_LIM.
REQ-014 SHALL select inst when the starvation counter equals STARVE_LIM and inst_sram_req is high.
REQ-015 SHALL set a grant lock (with owner id) when sram_req is high and sram_addr_ok is low; while locked, selection SHALL stay with the lock owner; the lock SHALL clear on the cycle sram_req and sram_addr_ok are both high.
REQ-016 SHALL return sram_addr_ok only to the selected master; the other master's addr_ok SHALL be 0.
REQ-017 SHALL push the owner id (0 = inst, 1 = data) into an OUTSTANDING-deep in-order owner FIFO on each accepted handshake (sram_req AND sram_addr_ok).
REQ-018 SHALL pop the FIFO on sram_data_ok when not empty, and assert data_ok with sram_rdata to the head owner in the same cycle (zero-cycle response latency); the other master's data_ok SHALL be 0.
REQ-019 SHALL handle simultaneous push and pop in one cycle with occupancy unchanged, including at full (pop frees the slot, push accepted) and at empty (pop ignored, push accepted).
REQ-020 SHALL wrap read/write pointers modulo OUTSTANDING; occupancy counter SHALL be log2(OUTSTANDING)+1 bits.
REQ-021 SHALL deassert sram_req and both addr_ok while full and no pop occurs that cycle.
REQ-022 SHALL ignore sram_data_ok while empty (no master data_ok) and set err_unexp_resp, held until reset.
REQ-023 SHALL increment the starvation counter (saturating at STARVE_LIM) on each accepted data handshake while inst_sram_req is high, and clear it on any accepted inst handshake or any cycle inst_sram_req is low.
REQ-024 SHALL drive rdata to both masters from sram_rdata unconditionally; only data_ok qualifies it.
REQ-025 SHALL require masters to hold req and payload stable until addr_ok; behaviour on withdrawal is undefined.

Reset
REQ-026 SHALL, on reset assertion, immediately clear FIFO pointers, occupancy, grant lock, starvation counter and err_unexp_resp to 0, independent of clk.
REQ-027 SHALL, during reset, drive sram_req, all addr_ok and all data_ok to 0; in-flight responses are discarded after reset.

Verification
REQ-028 SHALL verify: both masters req, slave addr_ok=1 every cycle -> data granted 4 times, 5th grant to inst, starvation counter back to 0.
REQ-029 SHALL verify: inst req with addr_ok low 3 cycles, data req arrives cycle 1 -> slave payload stays inst until addr_ok, data granted next cycle.
REQ-030 SHALL verify: 4 accepted reads (inst, data, data, inst), no data_ok -> 5th request blocked (sram_req=0); data_ok with rdata 0x11,0x22,0x33,0x44 -> delivered to inst,data,data,inst in order.
REQ-031 SHALL verify: at full, same-cycle sram_data_ok and new accepted request -> occupancy stays 4, response to head owner, new owner appended.
REQ-032 SHALL verify: sram_data_ok while empty -> no master data_ok, err_unexp_resp=1 until reset.
REQ-033 SHALL verify: reset asserted mid-cycle with 2 outstanding -> occupancy 0 and outputs 0 before next clk edge; post-reset single read completes normally.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like slave port.
// Tracks in-flight owners in order so responses return to the right master.
module sram_req_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_LIM  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata,

    output logic        err_unexp_resp
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);
    localparam logic [SW-1:0] LIM      = SW'(STARVE_LIM);

    logic                   lock_q, lock_d;
    logic                   owner_q, owner_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic sel_data;
    logic sel_req;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic head;

    // A held lock pins the payload until the slave takes it.
    always_comb begin
        sel_data = 1'b0;
        if (lock_q) begin
            sel_data = owner_q;
        end else if (data_sram_req && inst_sram_req) begin
            sel_data = (starve_q < LIM);
        end else begin
            sel_data = data_sram_req;
        end
    end

    assign sel_req = sel_data ? data_sram_req : inst_sram_req;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign pop     = sram_data_ok && !empty && !reset;
    assign head    = fifo_q[rptr_q];

    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign sram_req   = sel_req && (!full || pop) && !reset;
    assign push       = sram_req && sram_addr_ok;
    assign sram_wr    = sel_data ? data_sram_wr    : inst_sram_wr;
    assign sram_wen   = sel_data ? data_sram_wen   : inst_sram_wen;
    assign sram_addr  = sel_data ? data_sram_addr  : inst_sram_addr;
    assign sram_wdata = sel_data ? data_sram_wdata : inst_sram_wdata;

    assign inst_sram_addr_ok = push && !sel_data;
    assign data_sram_addr_ok = push && sel_data;
    assign inst_sram_data_ok = pop && !head;
    assign data_sram_data_ok = pop && head;
    assign inst_sram_rdata   = sram_rdata;
    assign data_sram_rdata   = sram_rdata;
    assign err_unexp_resp    = err_q;

    always_comb begin
        fifo_d   = fifo_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        err_d    = err_q;

        if (push) begin
            fifo_d[wptr_q] = sel_data;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (push) begin
            lock_d = 1'b0;
        end else if (sram_req && !sram_addr_ok) begin
            lock_d  = 1'b1;
            owner_d = sel_data;
        end

        if (!inst_sram_req) begin
            starve_d = '0;
        end else if (push && !sel_data) begin
            starve_d = '0;
        end else if (push && sel_data && (starve_q != LIM)) begin
            starve_d = starve_q + 1'b1;
        end

        if (sram_data_ok && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            lock_q   <= 1'b0;
            owner_q  <= 1'b0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: routing table plus multi-cycle sequences
// with an in-order owner scoreboard checked on every slave response.
module tb_sram_req_arbiter;

    localparam logic [31:0] IADDR = 32'h1000_0040;
    localparam logic [31:0] DADDR = 32'h2000_0080;
    localparam logic [31:0] IWDAT = 32'hAAAA_0001;
    localparam logic [31:0] DWDAT = 32'hBBBB_0002;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
    logic [3:0]  inst_sram_wen = 4'h3;
    logic [31:0] inst_sram_addr = IADDR, inst_sram_wdata = IWDAT;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
    logic [3:0]  data_sram_wen = 4'hC;
    logic [31:0] data_sram_addr = DADDR, data_sram_wdata = DWDAT;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        sram_req, sram_wr;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok = 1'b0, sram_data_ok = 1'b0;
    logic [31:0] sram_rdata = '0;
    logic        err_unexp_resp;

    int total = 0;
    int bad = 0;
    bit sb[$];

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(4), .STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
        .sram_rdata(sram_rdata),
        .err_unexp_resp(err_unexp_resp)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response side of the scoreboard: head owner must get data_ok.
    always @(negedge clk) begin
        bit o;
        if (sram_data_ok) begin
            if (sb.size() > 0) begin
                o = sb.pop_front();
                chk("rsp_inst_dok", {31'b0, inst_sram_data_ok}, {31'b0, !o});
                chk("rsp_data_dok", {31'b0, data_sram_data_ok}, {31'b0, o});
                chk("rsp_rdata", o ? data_sram_rdata : inst_sram_rdata,
                    sram_rdata);
            end else begin
                chk("spur_inst_dok", {31'b0, inst_sram_data_ok}, 32'd0);
                chk("spur_data_dok", {31'b0, data_sram_data_ok}, 32'd0);
            end
        end
    end

    task automatic set_in(input logic ir, input logic dr, input logic aok,
                          input logic dok, input logic [31:0] rd);
        inst_sram_req = ir;
        data_sram_req = dr;
        sram_addr_ok  = aok;
        sram_data_ok  = dok;
        sram_rdata    = rd;
    endtask

    task automatic wait_mid();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_in(0, 0, 0, 0, '0);
        inst_sram_wr = 1'b0;
        data_sram_wr = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       ir, iw, dr, dw, aok;
        logic       ereq;
        logic [1:0] esel;
        logic       eia, eda;
        string      name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "idle"};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, "i_rd_ok"};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, "i_wr_wait"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, "d_wr_ok"};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, "d_rd_wait"};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, "both_ok"};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, "both_wait"};

        // Asynchronous reset with requests pending: everything held low.
        #1;
        reset = 1'b1;
        set_in(1, 1, 1, 0, '0);
        #1;
        chk("rst_sram_req", {31'b0, sram_req}, 32'd0);
        chk("rst_inst_aok", {31'b0, inst_sram_addr_ok}, 32'd0);
        chk("rst_data_aok", {31'b0, data_sram_addr_ok}, 32'd0);
        chk("rst_err", {31'b0, err_unexp_resp}, 32'd0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        set_in(0, 0, 0, 0, '0);
        wait_drive();
        reset = 1'b0;

        foreach (vecs[i]) begin
            logic [31:0] ea, ew;
            logic [3:0]  en;
            logic        ewr;
            do_reset();
            inst_sram_wr = vecs[i].iw;
            data_sram_wr = vecs[i].dw;
            set_in(vecs[i].ir, vecs[i].dr, vecs[i].aok, 0, '0);
            wait_mid();
            chk({vecs[i].name, "_req"}, {31'b0, sram_req}, {31'b0, vecs[i].ereq});
            chk({vecs[i].name, "_iaok"}, {31'b0, inst_sram_addr_ok},
                {31'b0, vecs[i].eia});
            chk({vecs[i].name, "_daok"}, {31'b0, data_sram_addr_ok},
                {31'b0, vecs[i].eda});
            if (vecs[i].esel != 2'd0) begin
                ea  = (vecs[i].esel == 2'd2) ? DADDR : IADDR;
                ew  = (vecs[i].esel == 2'd2) ? DWDAT : IWDAT;
                en  = (vecs[i].esel == 2'd2) ? 4'hC : 4'h3;
                ewr = (vecs[i].esel == 2'd2) ? vecs[i].dw : vecs[i].iw;
                chk({vecs[i].name, "_addr"}, sram_addr, ea);
                chk({vecs[i].name, "_wdata"}, sram_wdata, ew);
                chk({vecs[i].name, "_wen"}, {28'b0, sram_wen}, {28'b0, en});
                chk({vecs[i].name, "_wr"}, {31'b0, sram_wr}, {31'b0, ewr});
            end
        end

        // Starvation: four data grants, then inst wins and counter clears.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1, 1, k >= 1, 32'h100 + k);
            wait_mid();
            chk("starve_gnt_data", {31'b0, data_sram_addr_ok}, {31'b0, k < 4});
            chk("starve_gnt_inst", {31'b0, inst_sram_addr_ok}, {31'b0, k == 4});
            if (k == 4) chk("starve_sat", 32'(dut.starve_q), 32'd4);
            sb.push_back(k < 4);
            wait_drive();
        end
        set_in(0, 0, 0, 1, 32'h105);
        wait_mid();
        chk("starve_clr", 32'(dut.starve_q), 32'd0);
        wait_drive();
        set_in(0, 0, 0, 0, '0);

        // Grant lock holds inst payload while slave stalls.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1, k >= 1, k == 3, 0, '0);
            wait_mid();
            chk("lock_addr", sram_addr, IADDR);
            chk("lock_req", {31'b0, sram_req}, 32'd1);
            chk("lock_iaok", {31'b0, inst_sram_addr_ok}, {31'b0, k == 3});
            chk("lock_daok", {31'b0, data_sram_addr_ok}, 32'd0);
            if (k == 3) sb.push_back(1'b0);
            wait_drive();
        end
        set_in(0, 1, 1, 0, '0);
        wait_mid();
        chk("lock_next_addr", sram_addr, DADDR);
        chk("lock_next_daok", {31'b0, data_sram_addr_ok}, 32'd1);
        sb.push_back(1'b1);
        wait_drive();
        set_in(0, 0, 0, 1, 32'hA5);
        wait_drive();
        set_in(0, 0, 0, 1, 32'h5A);
        wait_drive();
        set_in(0, 0, 0, 0, '0);

        // Fill to OUTSTANDING, blocked request, then pop+push at full.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bit o;
            o = (k == 1 || k == 2);
            set_in(!o, o, 1, 0, '0);
            wait_mid();
            chk("fill_aok", {31'b0, o ? data_sram_addr_ok : inst_sram_addr_ok},
                32'd1);
            sb.push_back(o);
            wait_drive();
        end
        set_in(0, 1, 1, 0, '0);
        wait_mid();
        chk("full_req", {31'b0, sram_req}, 32'd0);
        chk("full_daok", {31'b0, data_sram_addr_ok}, 32'd0);
        chk("full_cnt", 32'(dut.cnt_q), 32'd4);
        wait_drive();
        set_in(0, 1, 1, 1, 32'h11);
        wait_mid();
        chk("pp_req", {31'b0, sram_req}, 32'd1);
        chk("pp_daok", {31'b0, data_sram_addr_ok}, 32'd1);
        sb.push_back(1'b1);
        wait_drive();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 0, 1, 32'h22 + 32'(k) * 32'h11);
            wait_mid();
            chk("drain_cnt", 32'(dut.cnt_q), 32'(4 - k));
            wait_drive();
        end
        set_in(0, 0, 0, 0, '0);
        wait_mid();
        chk("drain_empty", 32'(dut.cnt_q), 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);

        // Unexpected response sets a sticky error.
        do_reset();
        set_in(0, 0, 0, 1, 32'hDEAD);
        wait_drive();
        set_in(0, 0, 0, 0, '0);
        wait_mid();
        chk("err_set", {31'b0, err_unexp_resp}, 32'd1);
        wait_drive();
        wait_drive();
        chk("err_hold", {31'b0, err_unexp_resp}, 32'd1);
        chk("err_cnt", 32'(dut.cnt_q), 32'd0);
        do_reset();
        chk("err_clr", {31'b0, err_unexp_resp}, 32'd0);

        // Mid-cycle reset with two in flight.
        set_in(1, 0, 1, 0, '0);
        wait_drive();
        set_in(0, 1, 1, 0, '0);
        wait_drive();
        set_in(0, 0, 0, 0, '0);
        chk("mr_pre_cnt", 32'(dut.cnt_q), 32'd2);
        #2;
        reset = 1'b1;
        sb.delete();
        set_in(1, 1, 1, 1, 32'h99);
        #1;
        chk("mr_cnt", 32'(dut.cnt_q), 32'd0);
        chk("mr_req", {31'b0, sram_req}, 32'd0);
        chk("mr_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
        chk("mr_dok", {30'b0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
        wait_drive();
        set_in(0, 0, 0, 0, '0);
        reset = 1'b0;
        set_in(1, 0, 1, 0, '0);
        wait_mid();
        chk("mr_post_iaok", {31'b0, inst_sram_addr_ok}, 32'd1);
        sb.push_back(1'b0);
        wait_drive();
        set_in(0, 0, 0, 1, 32'h77);
        wait_drive();
        set_in(0, 0, 0, 0, '0);
        wait_mid();
        chk("mr_post_cnt", 32'(dut.cnt_q), 32'd0);
        chk("mr_post_err", {31'b0, err_unexp_resp}, 32'd0);
        chk("mr_post_sb", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
